// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the cpu15 prefetching fetch unit.
package fetch_pkg;

   localparam int IW_DEF    = 15;
   localparam int AW_DEF    = 8;
   localparam int DEPTH_DEF = 4;

   typedef struct packed {
      logic [IW_DEF-1:0] word;
      logic [AW_DEF-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_pf_if.sv
// ROM port plus decoder handshake and redirect/halt controls of the fetch unit.
interface fetch_pf_if
   import fetch_pkg::*;
#(
   parameter int IW = IW_DEF,
   parameter int AW = AW_DEF
);

   logic          ROM_EN;
   logic [AW-1:0] ROM_ADDR;
   logic [IW-1:0] ROM_DATA;
   logic          IR_VALID;
   logic          IR_READY;
   logic [IW-1:0] IR_OUT;
   logic [AW-1:0] IR_PC;
   logic          JMP_EN;
   logic [AW-1:0] JMP_ADDR;
   logic          HALT;

   modport master (
      output ROM_EN, ROM_ADDR, IR_VALID, IR_OUT, IR_PC,
      input  ROM_DATA, IR_READY, JMP_EN, JMP_ADDR, HALT
   );

   modport slave (
      input  ROM_EN, ROM_ADDR, IR_VALID, IR_OUT, IR_PC,
      output ROM_DATA, IR_READY, JMP_EN, JMP_ADDR, HALT
   );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with wrap-around pointers and a flush that
// empties it in one edge. Head reads as zero while empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = DEPTH_DEF,
   parameter type entry_t = fetch_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  entry_t           data_i,
   output entry_t           data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      do_push  = push_i && !flush_i;
      do_pop   = pop_i && !empty_o && !flush_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; count_q alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !flush_i && !pop_i && full_o));

endmodule

// File: rtl/fetch_pf.sv
// Prefetching instruction fetch: owns the PC, tracks the one outstanding ROM
// read and feeds returned words through the prefetch queue to the decoder.
module fetch_pf
   import fetch_pkg::*;
#(
   parameter int          IW       = IW_DEF,
   parameter int          AW       = AW_DEF,
   parameter int          DEPTH    = DEPTH_DEF,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic        CLK_FT,
   input  logic        RSTN_FT,
   fetch_pf_if.master  bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [IW-1:0] word;
      logic [AW-1:0] pc;
   } entry_t;

   logic [AW-1:0]    pc_q, pc_d;
   logic [AW-1:0]    inf_pc_q, inf_pc_d;
   logic             inflight_q, inflight_d;
   logic             issue, push, pop;
   logic             empty, full;
   logic [CNT_W-1:0] occ;
   entry_t           push_entry, head;

   always_comb begin
      // Redirect outranks everything: no issue, no push, no pop that cycle.
      issue      = !bus.HALT && !bus.JMP_EN && ((int'(occ) + int'(inflight_q)) < DEPTH);
      push       = inflight_q && !bus.JMP_EN;
      pop        = !empty && bus.IR_READY && !bus.JMP_EN;
      push_entry = '{word: bus.ROM_DATA, pc: inf_pc_q};
      pc_d       = pc_q;
      inf_pc_d   = inf_pc_q;
      inflight_d = issue;
      if (bus.JMP_EN) begin
         pc_d = bus.JMP_ADDR;
      end else if (issue) begin
         pc_d     = pc_q + AW'(1);
         inf_pc_d = pc_q;
      end
   end

   always_ff @(posedge CLK_FT or negedge RSTN_FT) begin
      if (!RSTN_FT) begin
         pc_q       <= RESET_PC;
         inf_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         inf_pc_q   <= inf_pc_d;
         inflight_q <= inflight_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk     (CLK_FT),
      .rst_n   (RSTN_FT),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (bus.JMP_EN),
      .data_i  (push_entry),
      .data_o  (head),
      .count_o (occ),
      .empty_o (empty),
      .full_o  (full)
   );

   assign bus.ROM_EN   = issue;
   assign bus.ROM_ADDR = pc_q;
   assign bus.IR_VALID = !empty;
   assign bus.IR_OUT   = head.word;
   assign bus.IR_PC    = head.pc;

   a_issue_room: assert property (@(posedge CLK_FT) disable iff (!RSTN_FT)
      !(issue && full));

endmodule

// File: tb/tb_fetch_pf.sv
// Directed bench for fetch_pf: streaming, backpressure, redirect, PC wrap,
// halt and mid-stream reset, against a one-cycle ROM returning {7'h0, addr}.
module tb_fetch_pf;

   localparam int IW    = 15;
   localparam int AW    = 8;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fetch_pf_if #(.IW(IW), .AW(AW)) bus ();

   fetch_pf #(
      .IW       (IW),
      .AW       (AW),
      .DEPTH    (DEPTH),
      .RESET_PC (8'h10)
   ) dut (
      .CLK_FT  (clk),
      .RSTN_FT (rst_n),
      .bus     (bus)
   );

   logic [IW-1:0] rom_q;
   always @(posedge clk) if (bus.ROM_EN) rom_q <= {7'h0, bus.ROM_ADDR};
   assign bus.ROM_DATA = rom_q;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input logic [AW-1:0] pc);
      check({tag, ".valid"}, 32'(bus.IR_VALID), 32'd1);
      check({tag, ".pc"},    32'(bus.IR_PC),    32'(pc));
      check({tag, ".word"},  32'(bus.IR_OUT),   32'(pc));
   endtask

   task automatic check_empty(input string tag);
      check({tag, ".valid"}, 32'(bus.IR_VALID), 32'd0);
      check({tag, ".pc"},    32'(bus.IR_PC),    32'd0);
      check({tag, ".word"},  32'(bus.IR_OUT),   32'd0);
   endtask

   task automatic do_reset(input logic rdy);
      @(negedge clk);
      rst_n        = 1'b0;
      bus.IR_READY = rdy;
      bus.JMP_EN   = 1'b0;
      bus.JMP_ADDR = '0;
      bus.HALT     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n_req;
      bus.IR_READY = 1'b1;
      bus.JMP_EN   = 1'b0;
      bus.JMP_ADDR = '0;
      bus.HALT     = 1'b0;

      // Reset state and streaming from RESET_PC
      repeat (2) @(negedge clk);
      #1;
      check_empty("rst");
      check("rst.rom_addr", 32'(bus.ROM_ADDR), 32'h10);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         check("seq.rom_en",   32'(bus.ROM_EN),   32'd1);
         check("seq.rom_addr", 32'(bus.ROM_ADDR), 32'(16 + k));
         if (k < 2) check_empty("seq.head");
         else       check_head("seq.head", 8'(16 + k - 2));
      end

      // Backpressure: four requests, then ordered drain
      do_reset(1'b0);
      n_req = 0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         n_req += int'(bus.ROM_EN);
         if (k < 4) check("bp.rom_addr", 32'(bus.ROM_ADDR), 32'(16 + k));
      end
      check("bp.req_count", 32'(n_req), 32'd4);
      check("bp.rom_en_stall", 32'(bus.ROM_EN), 32'd0);
      check_head("bp.hold", 8'h10);
      tick();
      bus.IR_READY = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         check_head("bp.drain", 8'(16 + k));
         if (k == 1) begin
            check("bp.resume_en",   32'(bus.ROM_EN),   32'd1);
            check("bp.resume_addr", 32'(bus.ROM_ADDR), 32'h14);
         end
      end

      // Redirect while queue + inflight fill DEPTH
      do_reset(1'b0);
      repeat (4) tick();
      check_head("jmp.pre", 8'h10);
      bus.JMP_EN   = 1'b1;
      bus.JMP_ADDR = 8'h40;
      #1;
      check("jmp.rom_en_blocked", 32'(bus.ROM_EN), 32'd0);
      tick();
      bus.JMP_EN   = 1'b0;
      bus.IR_READY = 1'b1;
      #1;
      check_empty("jmp.t1");
      check("jmp.t1.rom_en",   32'(bus.ROM_EN),   32'd1);
      check("jmp.t1.rom_addr", 32'(bus.ROM_ADDR), 32'h40);
      tick();
      check_empty("jmp.t2");
      check("jmp.t2.rom_addr", 32'(bus.ROM_ADDR), 32'h41);
      tick();
      check_head("jmp.t3", 8'h40);
      tick();
      check_head("jmp.t4", 8'h41);

      // PC wrap through 0xFF
      tick();
      bus.JMP_EN   = 1'b1;
      bus.JMP_ADDR = 8'hFE;
      #1;
      tick();
      bus.JMP_EN = 1'b0;
      #1;
      check("wrap.addr0", 32'(bus.ROM_ADDR), 32'hFE);
      check_empty("wrap.t1");
      tick();
      check("wrap.addr1", 32'(bus.ROM_ADDR), 32'hFF);
      tick();
      check("wrap.addr2", 32'(bus.ROM_ADDR), 32'h00);
      check_head("wrap.h0", 8'hFE);
      tick();
      check_head("wrap.h1", 8'hFF);
      tick();
      check_head("wrap.h2", 8'h00);
      tick();
      check_head("wrap.h3", 8'h01);

      // HALT for five cycles mid-stream
      for (int k = 0; k < 5; k++) begin
         tick();
         bus.HALT = 1'b1;
         #1;
         check("halt.rom_en", 32'(bus.ROM_EN), 32'd0);
         if (k == 0)      check_head("halt.h", 8'h02);
         else if (k == 1) check_head("halt.h", 8'h03);
         else             check_empty("halt.empty");
      end
      tick();
      bus.HALT = 1'b0;
      #1;
      check("halt.resume_en",   32'(bus.ROM_EN),   32'd1);
      check("halt.resume_addr", 32'(bus.ROM_ADDR), 32'h04);
      tick();
      check("halt.next_addr", 32'(bus.ROM_ADDR), 32'h05);
      tick();
      check_head("halt.r0", 8'h04);
      tick();
      check_head("halt.r1", 8'h05);

      // Asynchronous reset with words queued and a read outstanding
      do_reset(1'b0);
      repeat (3) tick();
      check_head("mrst.pre", 8'h10);
      rst_n    = 1'b0;
      bus.HALT = 1'b1;
      #1;
      check_empty("mrst.now");
      check("mrst.rom_addr", 32'(bus.ROM_ADDR), 32'h10);
      repeat (2) @(negedge clk);
      rst_n        = 1'b1;
      bus.HALT     = 1'b0;
      bus.IR_READY = 1'b1;
      #1;
      check("mrst.c0.rom_en",   32'(bus.ROM_EN),   32'd1);
      check("mrst.c0.rom_addr", 32'(bus.ROM_ADDR), 32'h10);
      check_empty("mrst.c0");
      tick();
      check_empty("mrst.c1");
      tick();
      check_head("mrst.c2", 8'h10);
      tick();
      check_head("mrst.c3", 8'h11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
